// File: rtl/seq_sub.sv
// seq_sub: digit-serial subtractor, diff = a - b computed as a + ~b + 1, DIGIT bits per cycle, LSB first.
// Optional condition codes (zf/sf/of) are compiled in when SEQ_SUB_CC_EN is defined; otherwise they read 0.
module seq_sub #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Handshake: start is sampled on an edge only in IDLE or DONE (and never while rst=1);
  // busy is high for the N RUN cycles, done pulses for exactly one cycle with diff/flags valid.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       nb_q, nb_d;
  logic [WIDTH-DIGIT-1:0] res_q, res_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   carry_q, carry_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [WIDTH-1:0]       diff_q, diff_d;
  logic                   bout_q, bout_d;

  logic [DIGIT-1:0]       a_dig, nb_dig, sum_dig;
  logic [DIGIT:0]         rc;
  logic [WIDTH-1:0]       cat;

`ifdef SEQ_SUB_CC_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic zf_q, zf_d;
  logic sf_q, sf_d;
  logic of_q, of_d;
`endif

  // Operands are shifted right each RUN cycle, so the active digit is always the low slice.
  assign a_dig  = a_q[DIGIT-1:0];
  assign nb_dig = nb_q[DIGIT-1:0];

  always_comb begin
    rc[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      sum_dig[i] = a_dig[i] ^ nb_dig[i] ^ rc[i];
      rc[i+1]    = (a_dig[i] & nb_dig[i]) | (rc[i] & (a_dig[i] ^ nb_dig[i]));
    end
  end

  // New digit enters from the MSB side; after the last digit cat holds the whole difference.
  assign cat = {sum_dig, res_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    nb_d    = nb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SEQ_SUB_CC_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          nb_d    = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
`ifdef SEQ_SUB_CC_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        nb_d    = nb_q >> DIGIT;
        res_d   = cat[WIDTH-1:DIGIT];
        carry_d = rc[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          diff_d  = cat;
          bout_d  = ~rc[DIGIT];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
`ifdef SEQ_SUB_CC_EN
          zf_d    = (cat == '0);
          sf_d    = cat[WIDTH-1];
          of_d    = (a_msb_q != b_msb_q) && (cat[WIDTH-1] != a_msb_q);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      nb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SEQ_SUB_CC_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SEQ_SUB_CC_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign dbg_state = state_q;

`ifdef SEQ_SUB_CC_EN
  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;
`else
  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif

endmodule

// File: doc/seq_sub.md
# seq_sub

Multi-cycle digit-serial 64-bit subtractor computing `a - b` in two's complement (`a + ~b + 1`). Processes `DIGIT` bits per cycle, LSB first, under a start/done handshake. Sits beside the combinational ripple adder in the sequential processor's ALU path and serves SUB and compare operations where area matters more than latency. Optionally produces the condition codes ZF/SF/OF and a borrow-out.

## Interface

- `WIDTH`, default 64: operand width.
- `DIGIT`, default 4: bits processed per cycle. Must divide `WIDTH`. N = `WIDTH/DIGIT` cycles per operation.
- `clk`  in  1  the single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request. Sampled only in IDLE or DONE.
- `a`  in  WIDTH  minuend, captured on the accepting edge.
- `b`  in  WIDTH  subtrahend, captured on the accepting edge.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse: result valid.
- `diff`  out  WIDTH  `a - b` mod 2^WIDTH, held until the next completion.
- `bout`  out  1  borrow out: 1 iff unsigned `a < b`.
- `zf`  out  1  `diff == 0`.
- `sf`  out  1  `diff[WIDTH-1]`.
- `of`  out  1  signed overflow.

## Operation

- States: IDLE, RUN, DONE.
- IDLE/DONE + `start`=1:
  - Latch `a` and `~b`.
  - Carry register = 1; digit counter = 0.
  - Go to RUN.
- IDLE/DONE + `start`=0:
  - DONE goes to IDLE.
  - IDLE stays in IDLE.
- RUN, each cycle:
  - Add digit `counter` of the latched a, the latched ~b and carry, with a DIGIT-bit ripple add.
  - Shift the digit sum into the internal result register from the MSB side.
  - Update carry; increment the counter.
- RUN, on the cycle processing digit N-1:
  - Load `diff` from the assembled result, along with `bout`, `zf`, `sf` and `of`.
  - Go to DONE.
- Flag definitions:
  - `bout` = ~(final carry).
  - `zf` = (diff == 0).
  - `sf` = diff MSB.
  - `of` = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from the latched operands.
- `start` during RUN is ignored. The operation in flight is not disturbed.
- Operand inputs may change freely after the accepting edge.
- Outputs are registered. There are no combinational paths from inputs to outputs.
- Reset values, for every output: `busy`=0, `done`=0, `diff`=0, `bout`=0, `zf`=0, `sf`=0, `of`=0. State = IDLE; counter and carry are cleared.

## Timing

- Latency: `start` accepted at edge E; `done`=1 in the cycle following edge E+N. For defaults, N=16.
- `busy` is high in the cycles following edges E..E+N-1, i.e. exactly N cycles.
- `done` is high exactly one cycle. `diff` and the flags change only at the edge that raises `done`.
- Back-to-back operation: `start` held high during the DONE cycle is accepted. `done` pulses again N+1 cycles after the first `done`, giving a throughput of one result per N+1 cycles.
- Reset mid-RUN:
  - On the next edge, state = IDLE and all outputs take their reset values.
  - The partial result is discarded and no `done` is produced.
  - `start` is ignored on any edge where `rst`=1.
- Wrap-around:
  - Counter width is clog2(N).
  - Completion is detected at count N-1, not by overflow.

## Configuration

- `SEQ_SUB_CC_EN` defined:
  - The `zf`, `sf` and `of` registers and their logic are compiled in and behave as specified.
- `SEQ_SUB_CC_EN` undefined:
  - `zf`, `sf` and `of` are constant 0.
  - `diff`, `bout`, `busy` and `done` are unchanged, and so is timing.
  - No flag logic is synthesised.

## Test plan

- a=5, b=3, `start` for one cycle:
  - `done` arrives 16 cycles after the accepting edge (DIGIT=4).
  - diff=2, bout=0, zf=0, sf=0, of=0.
- a=3, b=5:
  - diff=0xFFFF_FFFF_FFFF_FFFE, bout=1, sf=1, zf=0, of=0.
- a=0x8000_0000_0000_0000, b=1:
  - diff=0x7FFF_FFFF_FFFF_FFFF, of=1, sf=0, bout=0.
- Equal operands and back-to-back starts:
  - a=b=0x1234_5678_9ABC_DEF0 gives diff=0, zf=1, bout=0.
  - A second start in the DONE cycle with a=0, b=0 gives `done` again 17 cycles later, diff=0, zf=1.
- Start during RUN, then reset:
  - A new `start` with different operands at cycle 5 of RUN is ignored; the first result is correct.
  - Then `rst` at cycle 8 of a new RUN: all outputs read 0 next cycle, `busy`=0, and no `done` follows for 20 cycles.
- Compile without `SEQ_SUB_CC_EN`:
  - Repeat the a=3, b=5 case.
  - diff and bout are identical to the enabled build; zf, sf and of read 0 throughout.
